// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU operations, operand sources, access sizes.
package id_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_BRANCH = 7'b1100011,
        OPC_LUI    = 7'b0110111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_e;

    typedef enum logic [1:0] {
        SRC_REG   = 2'd0,
        SRC_IMM   = 2'd1,
        SRC_UPPER = 2'd2
    } alusrc_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    // funct3 -> ALU op; sub only applies to the register-register add slot
    function automatic alu_e alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:         return sub ? ALU_SUB : ALU_ADD;
            3'b001:         return ALU_SLL;
            3'b010, 3'b011: return ALU_SLT;
            3'b100:         return ALU_XOR;
            3'b101:         return ALU_SRL;
            3'b110:         return ALU_OR;
            default:        return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/Decoder.sv
// Combinational instruction decoder; register fields are passed through raw for every format.
module Decoder
    import id_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        flush,
    output logic [6:0]  opcode,
    output logic [2:0]  func,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [1:0]  alusrc,
    output logic [2:0]  aluctrl,
    output logic        mreq,
    output logic        write,
    output logic [1:0]  size,
    output logic        rw
);

    always_comb begin
        opcode  = inst[6:0];
        func    = inst[14:12];
        rs1     = inst[19:15];
        rs2     = inst[24:20];
        rd      = inst[11:7];
        imm     = '0;
        alusrc  = SRC_REG;
        aluctrl = ALU_ADD;
        mreq    = 1'b0;
        write   = 1'b0;
        size    = SZ_BYTE;
        rw      = 1'b0;
        case (inst[6:0])
            OPC_LOAD: begin
                imm    = {{20{inst[31]}}, inst[31:20]};
                alusrc = SRC_IMM;
                mreq   = 1'b1;
                size   = inst[13:12];
                rw     = 1'b1;
            end
            OPC_STORE: begin
                imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                alusrc = SRC_IMM;
                mreq   = 1'b1;
                write  = 1'b1;
                size   = inst[13:12];
            end
            OPC_OP: begin
                aluctrl = alu_op(inst[14:12], inst[30]);
                rw      = 1'b1;
            end
            OPC_OP_IMM: begin
                imm     = {{20{inst[31]}}, inst[31:20]};
                alusrc  = SRC_IMM;
                aluctrl = alu_op(inst[14:12], 1'b0);
                rw      = 1'b1;
            end
            OPC_BRANCH: begin
                imm     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                aluctrl = ALU_SUB;
            end
            OPC_LUI: begin
                imm    = {inst[31:12], 12'b0};
                alusrc = SRC_UPPER;
                rw     = 1'b1;
            end
            default: ;
        endcase
        if (flush) begin
            opcode  = '0;
            func    = '0;
            rs1     = '0;
            rs2     = '0;
            rd      = '0;
            imm     = '0;
            alusrc  = '0;
            aluctrl = '0;
            mreq    = 1'b0;
            write   = 1'b0;
            size    = '0;
            rw      = 1'b0;
        end
    end

endmodule

// File: rtl/rf_param.sv
// NREGS x XLEN register file: two async read ports with write-through bypass, one sync write port, x0 fixed at zero.
module rf_param #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] raddr1,
    input  logic [RA_W-1:0] raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            wen,
    input  logic [RA_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (wen && (waddr == raddr1)) ? wdata : regs_q[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (wen && (waddr == raddr2)) ? wdata : regs_q[raddr2];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX pipeline register, valid/ready handshakes and a load-use interlock.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [2:0]      func,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output logic [XLEN-1:0] imm,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [RA_W-1:0] rd,
    output logic [1:0]      alusrc,
    output logic [2:0]      aluctrl,
    output logic            mreq,
    output logic            write,
    output logic [1:0]      size,
    output logic            rw
);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      func;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [1:0]      alusrc;
        logic [2:0]      aluctrl;
        logic            mreq;
        logic            write;
        logic [1:0]      size;
        logic            rw;
    } bundle_t;

    logic [6:0]      d_opcode;
    logic [2:0]      d_func;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic [31:0]     d_imm;
    logic [1:0]      d_alusrc;
    logic [2:0]      d_aluctrl;
    logic            d_mreq, d_write, d_rw;
    logic [1:0]      d_size;
    logic [RA_W-1:0] rs1_a, rs2_a;
    logic [XLEN-1:0] rd1, rd2;

    bundle_t dec_b, bundle_q, bundle_d;
    logic    valid_q, valid_d, hazard;

    // Squash happens at the pipeline register, so the decoder itself never flushes
    Decoder u_dec (
        .inst    (in_inst),
        .flush   (1'b0),
        .opcode  (d_opcode),
        .func    (d_func),
        .rs1     (d_rs1),
        .rs2     (d_rs2),
        .rd      (d_rd),
        .imm     (d_imm),
        .alusrc  (d_alusrc),
        .aluctrl (d_aluctrl),
        .mreq    (d_mreq),
        .write   (d_write),
        .size    (d_size),
        .rw      (d_rw)
    );

    assign rs1_a = d_rs1[RA_W-1:0];
    assign rs2_a = d_rs2[RA_W-1:0];

    rf_param #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1_a),
        .raddr2 (rs2_a),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .wen    (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    always_comb begin
        dec_b         = '0;
        dec_b.opcode  = d_opcode;
        dec_b.func    = d_func;
        dec_b.data1   = rd1;
        dec_b.data2   = rd2;
        dec_b.imm     = XLEN'($signed(d_imm));
        dec_b.rs1     = rs1_a;
        dec_b.rs2     = rs2_a;
        dec_b.rd      = d_rd[RA_W-1:0];
        dec_b.alusrc  = d_alusrc;
        dec_b.aluctrl = d_aluctrl;
        dec_b.mreq    = d_mreq;
        dec_b.write   = d_write;
        dec_b.size    = d_size;
        dec_b.rw      = d_rw;
    end

    // Load in the ID/EX register whose destination feeds either source field of the incoming instruction
    assign hazard = valid_q & bundle_q.mreq & ~bundle_q.write & bundle_q.rw & (bundle_q.rd != '0)
                  & ((bundle_q.rd == rs1_a) | (bundle_q.rd == rs2_a));

    assign in_ready = ~rst & ~flush & ~hazard & (~valid_q | out_ready);

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (~valid_q | out_ready) begin
            if (in_valid & ~hazard) begin
                valid_d  = 1'b1;
                bundle_d = dec_b;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid = valid_q;
    assign opcode    = bundle_q.opcode;
    assign func      = bundle_q.func;
    assign data1     = bundle_q.data1;
    assign data2     = bundle_q.data2;
    assign imm       = bundle_q.imm;
    assign rs1       = bundle_q.rs1;
    assign rs2       = bundle_q.rs2;
    assign rd        = bundle_q.rd;
    assign alusrc    = bundle_q.alusrc;
    assign aluctrl   = bundle_q.aluctrl;
    assign mreq      = bundle_q.mreq;
    assign write     = bundle_q.write;
    assign size      = bundle_q.size;
    assign rw        = bundle_q.rw;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe (XLEN=64) with a reference model checked every falling edge.
module tb_id_stage_pipe;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int RA_W  = 5;

    localparam logic [31:0] I_ADD6   = 32'h00528333; // add  x6,x5,x5
    localparam logic [31:0] I_ADD10  = 32'h00028533; // add  x10,x5,x0
    localparam logic [31:0] I_LW7    = 32'h0000A383; // lw   x7,0(x1)
    localparam logic [31:0] I_ADDI8  = 32'h00138413; // addi x8,x7,1
    localparam logic [31:0] I_ADDI2  = 32'hFFF00113; // addi x2,x0,-1
    localparam logic [31:0] I_RD9    = 32'h00048533; // add  x10,x9,x0
    localparam logic [31:0] I_RD0    = 32'h00000533; // add  x10,x0,x0
    localparam logic [31:0] I_RD3    = 32'h000185B3; // add  x11,x3,x0
    localparam logic [31:0] I_SW     = 32'h00532223; // sw   x5,4(x6)
    localparam logic [31:0] I_LUI    = 32'h12345637; // lui  x12,0x12345
    localparam logic [31:0] I_BEQ    = 32'h00000463; // beq  x0,x0,8
    localparam logic [31:0] I_SUB    = 32'h403100B3; // sub  x1,x2,x3

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0]     in_inst;
    logic [RA_W-1:0] wb_addr, rs1, rs2, rd;
    logic [XLEN-1:0] wb_data, data1, data2, imm;
    logic [6:0]      opcode;
    logic [2:0]      func, aluctrl;
    logic [1:0]      alusrc, size;
    logic            mreq, write, rw;

    int n_chk  = 0;
    int n_fail = 0;

    id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .func(func),
        .data1(data1), .data2(data2), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .alusrc(alusrc), .aluctrl(aluctrl), .mreq(mreq), .write(write), .size(size), .rw(rw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  func;
        logic [63:0] data1, data2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  alusrc;
        logic [2:0]  aluctrl;
        logic        mreq, write, rw;
        logic [1:0]  size;
    } mb_t;

    mb_t         exp_b = '{default: '0};
    logic        exp_valid = 1'b0;
    logic [63:0] mrf [32];
    mb_t         nb;
    logic        hz;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        logic [2:0] tab [8] = '{3'd0, 3'd5, 3'd7, 3'd7, 3'd4, 3'd6, 3'd3, 3'd2};
        return (f3 == 3'd0 && sub) ? 3'd1 : tab[f3];
    endfunction

    function automatic mb_t mdecode(input logic [31:0] w);
        mb_t b;
        b = '{default: '0};
        b.opcode = w[6:0];
        b.func   = w[14:12];
        b.rs1    = w[19:15];
        b.rs2    = w[24:20];
        b.rd     = w[11:7];
        case (w[6:0])
            7'h03: begin b.imm = 64'($signed(w[31:20])); b.alusrc = 2'd1; b.mreq = 1'b1;
                         b.size = w[13:12]; b.rw = 1'b1; end
            7'h23: begin b.imm = 64'($signed({w[31:25], w[11:7]})); b.alusrc = 2'd1; b.mreq = 1'b1;
                         b.write = 1'b1; b.size = w[13:12]; end
            7'h33: begin b.aluctrl = alu_of(w[14:12], w[30]); b.rw = 1'b1; end
            7'h13: begin b.imm = 64'($signed(w[31:20])); b.alusrc = 2'd1;
                         b.aluctrl = alu_of(w[14:12], 1'b0); b.rw = 1'b1; end
            7'h63: begin b.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); b.aluctrl = 3'd1; end
            7'h37: begin b.imm = 64'($signed({w[31:12], 12'b0})); b.alusrc = 2'd2; b.rw = 1'b1; end
            default: ;
        endcase
        return b;
    endfunction

    function automatic logic [63:0] mread(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return mrf[idx];
    endfunction

    function automatic logic mhazard(input logic [31:0] w);
        return exp_valid && exp_b.mreq && !exp_b.write && exp_b.rw && exp_b.rd != 5'd0
            && (exp_b.rd == w[19:15] || exp_b.rd == w[24:20]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid = 1'b0;
            exp_b     = '{default: '0};
            for (int i = 0; i < 32; i++) mrf[i] = 64'd0;
        end else begin
            nb       = mdecode(in_inst);
            nb.data1 = mread(nb.rs1);
            nb.data2 = mread(nb.rs2);
            hz       = mhazard(in_inst);
            if (flush) exp_valid = 1'b0;
            else if (!exp_valid || out_ready) begin
                if (in_valid && !hz) begin
                    exp_b     = nb;
                    exp_valid = 1'b1;
                end else exp_valid = 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("in_ready", 64'(in_ready),
            64'(!rst && !flush && !mhazard(in_inst) && (!exp_valid || out_ready)));
        chk("opcode", 64'(opcode), 64'(exp_b.opcode));
        chk("func", 64'(func), 64'(exp_b.func));
        chk("data1", data1, exp_b.data1);
        chk("data2", data2, exp_b.data2);
        chk("imm", imm, exp_b.imm);
        chk("rs1", 64'(rs1), 64'(exp_b.rs1));
        chk("rs2", 64'(rs2), 64'(exp_b.rs2));
        chk("rd", 64'(rd), 64'(exp_b.rd));
        chk("alusrc", 64'(alusrc), 64'(exp_b.alusrc));
        chk("aluctrl", 64'(aluctrl), 64'(exp_b.aluctrl));
        chk("mreq", 64'(mreq), 64'(exp_b.mreq));
        chk("write", 64'(write), 64'(exp_b.write));
        chk("size", 64'(size), 64'(exp_b.size));
        chk("rw", 64'(rw), 64'(exp_b.rw));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        in_valid = 1'b1; in_inst = I_ADD6; flush = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #1 rst = 1'b1;
        step(); step();
        chk("lit_rst_valid", 64'(out_valid), 64'd0);
        chk("lit_rst_ready", 64'(in_ready), 64'd0);
        chk("lit_rst_data1", data1, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        for (int i = 1; i < 32; i++) begin
            w = 32'h33 | (32'(i) << 15) | (32'(i) << 20);
            in_valid = 1'b1; in_inst = w;
            step();
            chk("lit_zero_rf", data1 | data2, 64'd0);
        end
        in_valid = 1'b0;
        step();

        // bypass from writeback into the instruction being accepted
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234; in_valid = 1'b1; in_inst = I_ADD6;
        step();
        chk("lit_bp_data1", data1, 64'h1234);
        chk("lit_bp_data2", data2, 64'h1234);
        chk("lit_bp_rd", 64'(rd), 64'd6);
        wb_en = 1'b0; in_inst = I_ADD10;
        step();
        chk("lit_x5", data1, 64'h1234);

        // load-use: one bubble
        in_inst = I_LW7;
        step();
        chk("lit_lw_valid", 64'(out_valid), 64'd1);
        in_inst = I_ADDI8;
        #1 chk("lit_lu_ready", 64'(in_ready), 64'd0);
        step();
        chk("lit_lu_bubble", 64'(out_valid), 64'd0);
        chk("lit_lu_ready2", 64'(in_ready), 64'd1);
        step();
        chk("lit_lu_issue", 64'(out_valid), 64'd1);
        chk("lit_lu_rd", 64'(rd), 64'd8);
        chk("lit_lu_imm", imm, 64'd1);

        // back-pressure
        in_inst = I_ADD6;
        step();
        out_ready = 1'b0; in_inst = I_ADDI2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_bpr_valid", 64'(out_valid), 64'd1);
            chk("lit_bpr_rd", 64'(rd), 64'd6);
            chk("lit_bpr_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("lit_bpr_next_rd", 64'(rd), 64'd2);
        chk("lit_imm_m1", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        in_valid = 1'b0;
        step();
        chk("lit_no_dup", 64'(out_valid), 64'd0);

        // flush with concurrent writeback
        in_valid = 1'b1; in_inst = I_ADD6; flush = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'hAA;
        step();
        chk("lit_flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; wb_en = 1'b0; in_inst = I_RD9;
        step();
        chk("lit_x9", data1, 64'hAA);

        // x0 write ignored, full-width write
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hFFFF;
        step();
        wb_en = 1'b0; in_valid = 1'b1; in_inst = I_RD0;
        step();
        chk("lit_x0", data1, 64'd0);
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'hDEADBEEF_00000001;
        step();
        wb_en = 1'b0; in_valid = 1'b1; in_inst = I_RD3;
        step();
        chk("lit_x3_wide", data1, 64'hDEADBEEF_00000001);

        // remaining formats
        in_inst = I_SW;
        step();
        chk("lit_sw_imm", imm, 64'd4);
        chk("lit_sw_write", 64'({mreq, write, rw}), 64'b110);
        chk("lit_sw_size", 64'(size), 64'd2);
        in_inst = I_LUI;
        step();
        chk("lit_lui_imm", imm, 64'h12345000);
        in_inst = I_BEQ;
        step();
        chk("lit_beq_imm", imm, 64'd8);
        in_inst = I_SUB;
        step();
        chk("lit_sub_alu", 64'(aluctrl), 64'd1);

        // async reset while stalled
        in_inst = I_ADD6;
        step();
        out_ready = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("lit_arst_valid", 64'(out_valid), 64'd0);
        chk("lit_arst_rd", 64'(rd), 64'd0);
        step();
        rst = 1'b0; out_ready = 1'b1; in_inst = I_ADD10;
        step();
        chk("lit_arst_rf", data1, 64'd0);
        in_valid = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
